// File: rtl/multi_nibble_adder.sv
// Sequential adder: {cout,sum} = a + b + cin, one nibble per cycle through a single 4-bit
// ripple-carry adder. Define MULTI_NIBBLE_ADDER_OVF_EN to add the two's-complement ovf output.
module multi_nibble_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
`ifdef MULTI_NIBBLE_ADDER_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            out_valid_q, out_valid_d;

  logic [3:0] nib_a, nib_b, nib_s;
  logic [4:0] rc;

  assign nib_a = a_q[int'(idx_q) * 4 +: 4];
  assign nib_b = b_q[int'(idx_q) * 4 +: 4];
  assign rc[0] = carry_q;

  // Four full-adder cells chained into the shared nibble adder.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign nib_s[i] = nib_a[i] ^ nib_b[i] ^ rc[i];
    assign rc[i+1]  = (nib_a[i] & nib_b[i]) | (rc[i] & (nib_a[i] ^ nib_b[i]));
  end

`ifdef MULTI_NIBBLE_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
`ifdef MULTI_NIBBLE_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    in_ready    = (state_q == StIdle) && !rst;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d[int'(idx_q) * 4 +: 4] = nib_s;
        carry_d = rc[4];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d      = rc[4];
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = StDone;
`ifdef MULTI_NIBBLE_ADDER_OVF_EN
          ovf_d = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef MULTI_NIBBLE_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef MULTI_NIBBLE_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef MULTI_NIBBLE_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multi_nibble_adder.sv
// Directed self-checking bench for multi_nibble_adder (NIBBLES=4); inputs driven and outputs
// sampled on the falling edge.
module tb_multi_nibble_adder;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef MULTI_NIBBLE_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  multi_nibble_adder #(.NIBBLES(NIBBLES)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef MULTI_NIBBLE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation and measure, in falling edges after the driving one, when out_valid
  // rises: the accepting edge plus NIBBLES ADD edges puts it at falling edge NIBBLES+1.
  task automatic issue(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv);
    int lat;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~av;
    b        = ~bv;
    cin      = ~cv;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(NIBBLES + 1));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] exp_sum,
                              input logic exp_cout, input logic exp_ovf);
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check_eq({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check_eq({tag, "_busy"}, 32'(in_ready), 32'd0);
`ifdef MULTI_NIBBLE_ADDER_OVF_EN
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected x ovf expectation for %s", tag);
`endif
  endtask

  // Handshake the result; the block must be back in IDLE with the result retained.
  task automatic release_result(input string tag, input logic [W-1:0] exp_sum,
                                input logic exp_cout);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_kept_sum"}, 32'(sum), 32'(exp_sum));
    check_eq({tag, "_kept_cout"}, 32'(cout), 32'(exp_cout));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf);
    issue(tag, av, bv, cv);
    check_result(tag, exp_sum, exp_cout, exp_ovf);
    release_result(tag, exp_sum, exp_cout);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    run_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

    // out_ready already high before out_valid: ignored in ADD, consumed in the first DONE cycle.
    out_ready = 1'b1;
    issue("ripple", 16'h00FF, 16'h0001, 1'b0);
    check_result("ripple", 16'h0100, 1'b0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("ripple_ov_drop", 32'(out_valid), 32'd0);
    check_eq("ripple_idle_rdy", 32'(in_ready), 32'd1);

    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("wrap", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("mixed", 16'hA5C3, 16'h5A3C, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // Result held under backpressure; new operands offered meanwhile must be ignored.
    issue("hold", 16'h1234, 16'h4321, 1'b1);
    in_valid = 1'b1;
    a        = 16'h0F0F;
    b        = 16'h0101;
    cin      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_sum", 32'(sum), 32'h5556);
      check_eq("hold_busy", 32'(in_ready), 32'd0);
    end
    // in_valid still high on the handshake edge: no same-cycle re-accept.
    release_result("hold", 16'h5556, 1'b0);
    in_valid = 1'b0;

    // Reset during the second ADD cycle aborts with no result.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_valid", 32'(out_valid), 32'd0);
    check_eq("abort_sum", 32'(sum), 32'd0);
    check_eq("abort_cout", 32'(cout), 32'd0);
    check_eq("abort_rdy_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("abort_rdy_after", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("abort_no_result", 32'(seen), 32'd0);

    run_op("recover", 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
